// File: rtl/arb_pkg.sv
// Shared types, sizing constants and the rotating first-set search for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NREQ         = 8;
    localparam int IDXW         = 3;
    localparam int MAX_HOLD_DFLT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Index of the first set bit of req, scanning from ptr upward with wrap.
    function automatic logic [IDXW-1:0] rr_find_first(input logic [IDXW-1:0] ptr,
                                                      input logic [NREQ-1:0] req);
        logic [2*NREQ-1:0] rot;
        logic [IDXW-1:0]   off;
        rot = {req, req} >> ptr;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// Combinational one-hot to binary encoder; each output bit is the OR of the inputs whose index has that bit set.
module arb_onehot_enc
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] onehot_i,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int b = 0; b < IDXW; b++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((i >> b) & 1) == 1) idx_o[b] = idx_o[b] | onehot_i[i];
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-release ownership.
// Define ARB_WATCHDOG_EN to bound each ownership to MAX_HOLD cycles and pulse timeout on a forced release.
module rr_req_arbiter8
    import arb_pkg::*;
`ifdef ARB_WATCHDOG_EN
#(
    parameter int MAX_HOLD = MAX_HOLD_DFLT
)
`endif
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    arb_state_e      state_q;
    logic [IDXW-1:0] ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic            release_req;

    // done and a dropped owner request in the same cycle are one release.
    assign release_req = done | ~|(req & gnt_q);

`ifdef ARB_WATCHDOG_EN
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HCW-1:0] hold_cnt_q;
    logic           timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q      <= NREQ'(1) << rr_find_first(ptr_q, req);
                        hold_cnt_q <= '0;
                        state_q    <= OWN;
                    end
                end
                OWN: begin
                    if (release_req) begin
                        gnt_q   <= '0;
                        ptr_q   <= gnt_idx + IDXW'(1);
                        state_q <= IDLE;
                    end else if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
                        gnt_q     <= '0;
                        ptr_q     <= gnt_idx + IDXW'(1);
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout = timeout_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q   <= NREQ'(1) << rr_find_first(ptr_q, req);
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    if (release_req) begin
                        gnt_q   <= '0;
                        ptr_q   <= gnt_idx + IDXW'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    arb_onehot_enc u_enc (
        .onehot_i (gnt_q),
        .idx_o    (gnt_idx)
    );

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;

endmodule
